// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan driver.
//   seg_t    - segment vector, seg[0]=a .. seg[6]=g, active-low
//   HEX_SEG  - active-low hex glyph table indexed by nibble value
//   SEG_OFF  - all segments dark
package seg7_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_OFF = 7'b1111111;

    // Glyphs for 0-9, A, b, C, d, E, F (leftmost literal bit is segment a).
    localparam seg_t HEX_SEG [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low segment pattern.
//   nibble  in   4-bit value to display
//   seg     out  active-low segments a..g
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [0:6] seg
);

    // Table lookup of the glyph for the incoming nibble.
    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed NUM_DIGITS seven-segment display driver
// with per-digit decimal points, leading-zero suppression, 16-level PWM
// brightness and a frame-aligned valid/ready load path.
//   clk_100MHz   in   system clock
//   reset        in   asynchronous active-high reset
//   load_value   in   hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   load_dp      in   decimal-point enables, 1 = lit
//   load_valid   in   load request
//   load_ready   out  pending slot free
//   lz_suppress  in   leading-zero suppression enable (live)
//   blank        in   force all outputs dark (live)
//   brightness   in   0 = dimmest, 15 = full on (live)
//   seg          out  active-low segments a..g
//   dp           out  active-low decimal point
//   an           out  active-low anodes
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    lz_suppress,
    input  logic                    blank,
    input  logic [3:0]              brightness,
    output logic [0:6]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int TICKS  = CLK_HZ / REFRESH_HZ;
    localparam int TICK_W = $clog2(TICKS);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W  = 4 * NUM_DIGITS;

    logic [TICK_W-1:0]     tick_cnt_r;
    logic [IDX_W-1:0]      digit_idx_r;
    logic [VAL_W-1:0]      shadow_value_r;
    logic [NUM_DIGITS-1:0] shadow_dp_r;
    logic [VAL_W-1:0]      pending_value_r;
    logic [NUM_DIGITS-1:0] pending_dp_r;
    logic                  pending_full_r;
    logic [0:6]            seg_r;
    logic                  dp_r;
    logic [NUM_DIGITS-1:0] an_r;

    logic                  tick_wrap_s;
    logic                  digit_wrap_s;
    logic                  frame_end_s;
    logic                  xfer_s;
    logic [3:0]            nibble_s;
    logic                  dp_bit_s;
    logic [0:6]            digit_seg_s;
    logic                  upper_nz_s;
    logic                  suppress_s;
    logic [31:0]           on_ticks_s;
    logic                  slot_on_s;
    logic [NUM_DIGITS-1:0] anode_sel_s;
    logic [0:6]            seg_next_s;
    logic                  dp_next_s;
    logic [NUM_DIGITS-1:0] an_next_s;

    // Frame position and handshake qualifiers.
    always_comb begin
        tick_wrap_s  = (tick_cnt_r == TICK_W'(TICKS - 1));
        digit_wrap_s = (digit_idx_r == IDX_W'(NUM_DIGITS - 1));
        frame_end_s  = tick_wrap_s && digit_wrap_s;
        load_ready   = !pending_full_r;
        xfer_s       = load_valid && !pending_full_r;
    end

    // Prescaler and digit scan counters; they free-run, even while blanked.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            tick_cnt_r  <= {TICK_W{1'b0}};
            digit_idx_r <= {IDX_W{1'b0}};
        end else if (tick_wrap_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            if (digit_wrap_s) begin
                digit_idx_r <= {IDX_W{1'b0}};
            end else begin
                digit_idx_r <= digit_idx_r + IDX_W'(1);
            end
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // Pending/shadow double buffer: shadow only changes at a frame end, so a
    // frame is always drawn from one consistent value.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            pending_value_r <= {VAL_W{1'b0}};
            pending_dp_r    <= {NUM_DIGITS{1'b0}};
            pending_full_r  <= 1'b0;
            shadow_value_r  <= {VAL_W{1'b0}};
            shadow_dp_r     <= {NUM_DIGITS{1'b0}};
        end else begin
            // A transfer needs an empty pending slot, so it can never collide
            // with the frame-end move below; a frame-end transfer waits a frame.
            if (xfer_s) begin
                pending_value_r <= load_value;
                pending_dp_r    <= load_dp;
                pending_full_r  <= 1'b1;
            end else if (frame_end_s && pending_full_r) begin
                shadow_value_r <= pending_value_r;
                shadow_dp_r    <= pending_dp_r;
                pending_full_r <= 1'b0;
            end else begin
                pending_full_r <= pending_full_r;
            end
        end
    end

    // Select the current digit's nibble, dp bit and anode pattern, and find
    // whether any nibble at or above the current digit is non-zero.
    always_comb begin
        nibble_s    = 4'h0;
        dp_bit_s    = 1'b0;
        upper_nz_s  = 1'b0;
        anode_sel_s = {NUM_DIGITS{1'b1}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nibble_s = (digit_idx_r == IDX_W'(i)) ? shadow_value_r[i*4 +: 4] : nibble_s;
            dp_bit_s = (digit_idx_r == IDX_W'(i)) ? shadow_dp_r[i] : dp_bit_s;
            anode_sel_s[i] = (digit_idx_r != IDX_W'(i));
            upper_nz_s = upper_nz_s
                       | ((IDX_W'(i) >= digit_idx_r) && (shadow_value_r[i*4 +: 4] != 4'h0));
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nibble_s),
        .seg    (digit_seg_s)
    );

    // Brightness gate and blanking/suppression priority for the next output.
    always_comb begin
        // (brightness+1)/16 of the slot; 15 yields exactly TICKS (full duty).
        on_ticks_s = ((32'(brightness) + 32'd1) * 32'(TICKS)) >> 4;
        slot_on_s  = (32'(tick_cnt_r) < on_ticks_s);
        // Digit 0 is never suppressed so an all-zero value still shows "0".
        suppress_s = lz_suppress && (digit_idx_r != {IDX_W{1'b0}}) && !upper_nz_s;
        if (blank) begin
            an_next_s  = {NUM_DIGITS{1'b1}};
            seg_next_s = SEG_OFF;
            dp_next_s  = 1'b1;
        end else begin
            an_next_s  = slot_on_s ? anode_sel_s : {NUM_DIGITS{1'b1}};
            seg_next_s = suppress_s ? SEG_OFF : digit_seg_s;
            dp_next_s  = ~dp_bit_s;
        end
    end

    // Registered display outputs, one cycle behind the counter state.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            an_r  <= {NUM_DIGITS{1'b1}};
            seg_r <= SEG_OFF;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_next_s;
            seg_r <= seg_next_s;
            dp_r  <= dp_next_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (TICKS=10, 4 digits). Expected display
// words are queued per sample cycle when stimulus is applied and compared
// when that cycle's outputs are sampled on the falling edge.
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic [15:0] load_value;
    logic [3:0]  load_dp;
    logic        load_valid;
    logic        load_ready;
    logic        lz_suppress;
    logic        blank;
    logic [3:0]  brightness;
    logic [0:6]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         at;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb_q[$];

    seg7_scan_driver #(
        .CLK_HZ     (1000),
        .REFRESH_HZ (100),
        .NUM_DIGITS (4)
    ) dut (
        .clk_100MHz  (clk),
        .reset       (reset),
        .load_value  (load_value),
        .load_dp     (load_dp),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .lz_suppress (lz_suppress),
        .blank       (blank),
        .brightness  (brightness),
        .seg         (seg),
        .dp          (dp),
        .an          (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue expected outputs for sample cycles first..first+n-1. The sample
    // after edge c shows counter position c-1 (position 0 = release of reset).
    task automatic push_span(input int first, input int n, input logic [15:0] val,
                             input logic [3:0] dpv, input logic lz, input int on,
                             input logic blk);
        exp_t        e;
        int          pos;
        int          idx;
        int          tk;
        logic [15:0] upper;
        logic        supp;
        for (int k = 0; k < n; k++) begin
            e.at  = first + k;
            pos   = e.at - 1;
            idx   = (pos / 10) % 4;
            tk    = pos % 10;
            upper = val >> (idx * 4);
            supp  = lz && (idx > 0) && (upper == 16'h0000);
            if (blk) begin
                e.an  = 4'b1111;
                e.seg = 7'b1111111;
                e.dp  = 1'b1;
            end else begin
                e.an  = (tk < on) ? ~(4'b0001 << idx) : 4'b1111;
                e.seg = supp ? 7'b1111111 : glyph(val[idx*4 +: 4]);
                e.dp  = ~dpv[idx];
            end
            sb_q.push_back(e);
        end
    endtask

    // One clock: advance, sample on the falling edge, retire due expectations.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            chk($sformatf("sb_cycle@%0d", cyc), 32'(cyc), 32'(e.at));
            chk($sformatf("an@%0d", cyc), 32'(an), 32'(e.an));
            chk($sformatf("seg@%0d", cyc), 32'(seg), 32'(e.seg));
            chk($sformatf("dp@%0d", cyc), 32'(dp), 32'(e.dp));
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) cycle();
    endtask

    initial begin
        reset       = 1'b1;
        load_value  = 16'h0000;
        load_dp     = 4'b0000;
        load_valid  = 1'b0;
        lz_suppress = 1'b0;
        blank       = 1'b0;
        brightness  = 4'd15;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_seg", 32'(seg), 32'h0000007F);
        chk("rst_dp", 32'(dp), 32'h00000001);
        chk("rst_ready", 32'(load_ready), 32'h00000001);
        reset = 1'b0;
        cyc   = 0;

        // Zero shadow shows "0" on digit 0 one cycle after release.
        push_span(1, 40, 16'h0000, 4'b0000, 1'b0, 10, 1'b0);
        cycle();

        // Load and scan: 12AF applied at the first frame end.
        load_value = 16'h12AF;
        load_dp    = 4'b0000;
        load_valid = 1'b1;
        cycle();
        load_valid = 1'b0;
        chk("ld_ready_low", 32'(load_ready), 32'h0);
        push_span(41, 80, 16'h12AF, 4'b0000, 1'b0, 10, 1'b0);
        run_to(39);
        chk("ld_ready_before_fe", 32'(load_ready), 32'h0);
        cycle();
        chk("ld_ready_after_fe", 32'(load_ready), 32'h1);

        // Handshake: 1111 accepted, 2222 held until ready rises.
        run_to(81);
        load_value = 16'h1111;
        load_valid = 1'b1;
        cycle();
        chk("hs_ready_low", 32'(load_ready), 32'h0);
        load_value = 16'h2222;
        push_span(121, 40, 16'h1111, 4'b0000, 1'b0, 10, 1'b0);
        push_span(161, 40, 16'h2222, 4'b0000, 1'b0, 10, 1'b0);
        run_to(119);
        chk("hs_ready_held", 32'(load_ready), 32'h0);
        cycle();
        chk("hs_ready_rise", 32'(load_ready), 32'h1);
        cycle();
        load_valid = 1'b0;
        chk("hs_second_taken", 32'(load_ready), 32'h0);

        // Leading-zero suppression.
        run_to(201);
        load_value  = 16'h0050;
        load_dp     = 4'b0100;
        load_valid  = 1'b1;
        lz_suppress = 1'b1;
        cycle();
        load_valid = 1'b0;
        push_span(241, 40, 16'h0050, 4'b0100, 1'b1, 10, 1'b0);
        run_to(241);
        load_value = 16'h0000;
        load_dp    = 4'b0000;
        load_valid = 1'b1;
        cycle();
        load_valid = 1'b0;
        push_span(281, 40, 16'h0000, 4'b0000, 1'b1, 10, 1'b0);

        // Brightness 0 then 7.
        run_to(320);
        brightness  = 4'd0;
        lz_suppress = 1'b0;
        push_span(321, 40, 16'h0000, 4'b0000, 1'b0, 0, 1'b0);
        run_to(360);
        brightness = 4'd7;
        push_span(361, 40, 16'h0000, 4'b0000, 1'b0, 5, 1'b0);

        // Blank mid-frame, then resume at the running digit.
        run_to(400);
        brightness = 4'd15;
        push_span(401, 10, 16'h0000, 4'b0000, 1'b0, 10, 1'b0);
        run_to(410);
        blank = 1'b1;
        push_span(411, 10, 16'h0000, 4'b0000, 1'b0, 10, 1'b1);
        run_to(420);
        blank = 1'b0;
        push_span(421, 19, 16'h0000, 4'b0000, 1'b0, 10, 1'b0);

        // Load accepted in the frame-end cycle waits one full frame.
        run_to(439);
        load_value = 16'hAB0C;
        load_dp    = 4'b0001;
        load_valid = 1'b1;
        push_span(440, 41, 16'h0000, 4'b0000, 1'b0, 10, 1'b0);
        push_span(481, 40, 16'hAB0C, 4'b0001, 1'b0, 10, 1'b0);
        cycle();
        load_valid = 1'b0;
        chk("fe_load_pending", 32'(load_ready), 32'h0);

        // Reset mid-frame with a pending value that must be discarded.
        run_to(521);
        load_value = 16'h5555;
        load_dp    = 4'b1111;
        load_valid = 1'b1;
        cycle();
        load_valid = 1'b0;
        chk("mid_pending_full", 32'(load_ready), 32'h0);
        run_to(525);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_an", 32'(an), 32'h0000000F);
        chk("mid_rst_seg", 32'(seg), 32'h0000007F);
        chk("mid_rst_dp", 32'(dp), 32'h00000001);
        chk("mid_rst_ready", 32'(load_ready), 32'h00000001);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        push_span(1, 80, 16'h0000, 4'b0000, 1'b0, 10, 1'b0);
        run_to(80);
        chk("post_rst_ready", 32'(load_ready), 32'h1);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
